// File: rtl/nand_share_pkg.sv
// Shared types and defaults for the NAND share arbiter slice.
// Optional build macro: NAND_SHARE_FIXED_PRIO_EN (fixed lowest-index priority).
package nand_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned ID_W      = $clog2(DEF_N_REQ);

endpackage

// File: rtl/nand_share_arbiter_if.sv
// Request/operand and response bundle between requesters, the consumer and the arbiter.
// Optional build macro: NAND_SHARE_FIXED_PRIO_EN (no effect on this interface).
interface nand_share_arbiter_if
    import nand_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic [IDX_W-1:0]       rsp_id;
    logic [WIDTH-1:0]       rsp_y;
    logic                   rsp_ready;
    logic                   busy;

    // Requesters and response consumer side
    modport master (
        output req, a_in, b_in, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_y, busy
    );

    // Arbiter side
    modport slave (
        input  req, a_in, b_in, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_y, busy
    );

endinterface

// File: rtl/nand_rr_pick.sv
// Combinational winner selection: (req, ptr) -> one-hot winner, index and any-request flag.
// Optional build macro: NAND_SHARE_FIXED_PRIO_EN selects lowest set index, ignoring ptr.
module nand_rr_pick
    import nand_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         win_oh,
    output logic [$clog2(N_REQ)-1:0] win_idx,
    output logic                     any
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic             found;
    logic [IDX_W:0]   slot;

    assign any = |req;

`ifdef NAND_SHARE_FIXED_PRIO_EN
    // Fixed priority: first set bit from index 0 upward wins
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        slot    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slot = (IDX_W+1)'(i);
            if (!found && req[slot[IDX_W-1:0]]) begin
                found                   = 1'b1;
                win_idx                 = slot[IDX_W-1:0];
                win_oh[slot[IDX_W-1:0]] = 1'b1;
            end
        end
    end
`else
    // Round robin: first set bit searching ptr, ptr+1, ... with wrap to 0
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        slot    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slot = {1'b0, ptr} + (IDX_W+1)'(i);
            if (slot >= (IDX_W+1)'(N_REQ)) begin
                slot = slot - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[slot[IDX_W-1:0]]) begin
                found                   = 1'b1;
                win_idx                 = slot[IDX_W-1:0];
                win_oh[slot[IDX_W-1:0]] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/nand_share_arbiter.sv
// Shares one WIDTH-bit bitwise NAND unit between N_REQ requesters.
// Captures the winner's operands on grant, evaluates, then holds the result
// on a valid/ready response channel until accepted.
// Optional build macro: NAND_SHARE_FIXED_PRIO_EN (fixed priority, ptr held at 0).
module nand_share_arbiter
    import nand_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    nand_share_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_y_q, rsp_y_d;

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    nand_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = EVAL;
            EVAL:    state_d = RESP;
            RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        gnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    a_d   = bus.a_in[pick_idx*WIDTH +: WIDTH];
                    b_d   = bus.b_in[pick_idx*WIDTH +: WIDTH];
                    id_d  = pick_idx;
                    gnt_d = pick_oh;
                end
            end
            EVAL: begin
                rsp_y_d     = ~(a_q & b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef NAND_SHARE_FIXED_PRIO_EN
                ptr_d       = '0;
`else
                ptr_d       = (id_q == IDX_W'(N_REQ-1)) ? '0 : id_q + 1'b1;
`endif
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Directed self-checking bench for nand_share_arbiter (default round-robin build).
module tb_nand_share_arbiter;

    logic clk;
    logic rst;

    nand_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    nand_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot operands {3,2,1,0}: a={C3,55,F0,0F} b={81,AA,3C,FF}
    // NAND results: slot0=F0, slot1=CF, slot2=FF, slot3=7E
    localparam logic [31:0] A_OPS = 32'hC355_F00F;
    localparam logic [31:0] B_OPS = 32'h81AA_3CFF;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic [7:0] y;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(string nm, logic r, logic [3:0] rq, logic rd,
                                logic [3:0] g, logic v, logic [1:0] id, logic [7:0] y, logic b);
        vec_t e;
        e.name = nm; e.rst = r; e.req = rq; e.rdy = rd;
        e.gnt = g; e.vld = v; e.id = id; e.y = y; e.busy = b;
        tbl.push_back(e);
    endfunction

    task automatic chk(string nm, logic [3:0] g, logic v, logic [1:0] id, logic [7:0] y, logic b);
        checks++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.busy} !== {g, v, id, y, b}) begin
            errors++;
            $display("FAIL %s: got gnt=%b vld=%b id=%0d y=%h busy=%b, want gnt=%b vld=%b id=%0d y=%h busy=%b",
                     nm, bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.busy, g, v, id, y, b);
        end
    endtask

    // Drive inputs at the falling edge, sample #1 after the following rising edge
    task automatic step(logic r, logic [3:0] rq, logic rd);
        @(negedge clk);
        rst           = r;
        bus.req       = rq;
        bus.rsp_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.a_in      = A_OPS;
        bus.b_in      = B_OPS;
        bus.rsp_ready = 1'b1;

        //   name        rst req      rdy gnt      vld id y      busy
        add("reset0",    1, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0);
        add("t2_gnt",    0, 4'b0010, 1, 4'b0010, 0, 0, 8'h00, 1);
        add("t2_rsp",    0, 4'b0000, 1, 4'b0000, 1, 1, 8'hCF, 1);
        add("t2_idle",   0, 4'b0000, 1, 4'b0000, 0, 1, 8'hCF, 0);
        add("reset1",    1, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0);
        add("t3_g0",     0, 4'b1111, 1, 4'b0001, 0, 0, 8'h00, 1);
        add("t3_r0",     0, 4'b1111, 1, 4'b0000, 1, 0, 8'hF0, 1);
        add("t3_i0",     0, 4'b1111, 1, 4'b0000, 0, 0, 8'hF0, 0);
        add("t3_g1",     0, 4'b1111, 1, 4'b0010, 0, 0, 8'hF0, 1);
        add("t3_r1",     0, 4'b1111, 1, 4'b0000, 1, 1, 8'hCF, 1);
        add("t3_i1",     0, 4'b1111, 1, 4'b0000, 0, 1, 8'hCF, 0);
        add("t3_g2",     0, 4'b1111, 1, 4'b0100, 0, 1, 8'hCF, 1);
        add("t3_r2",     0, 4'b1111, 1, 4'b0000, 1, 2, 8'hFF, 1);
        add("t3_i2",     0, 4'b1111, 1, 4'b0000, 0, 2, 8'hFF, 0);
        add("t3_g3",     0, 4'b1111, 1, 4'b1000, 0, 2, 8'hFF, 1);
        add("t3_r3",     0, 4'b1111, 1, 4'b0000, 1, 3, 8'h7E, 1);
        add("t3_i3",     0, 4'b1111, 1, 4'b0000, 0, 3, 8'h7E, 0);
        add("t3_g0b",    0, 4'b1111, 1, 4'b0001, 0, 3, 8'h7E, 1);
        add("t3_r0b",    0, 4'b0000, 1, 4'b0000, 1, 0, 8'hF0, 1);
        add("t3_i0b",    0, 4'b0000, 1, 4'b0000, 0, 0, 8'hF0, 0);
        add("t5_g2",     0, 4'b0100, 1, 4'b0100, 0, 0, 8'hF0, 1);
        add("t5_r2",     0, 4'b0000, 1, 4'b0000, 1, 2, 8'hFF, 1);
        add("t5_i2",     0, 4'b0000, 1, 4'b0000, 0, 2, 8'hFF, 0);
        add("t5_g3",     0, 4'b1001, 1, 4'b1000, 0, 2, 8'hFF, 1);
        add("t5_r3",     0, 4'b1001, 1, 4'b0000, 1, 3, 8'h7E, 1);
        add("t5_i3",     0, 4'b1001, 1, 4'b0000, 0, 3, 8'h7E, 0);
        add("t5_g0",     0, 4'b1001, 1, 4'b0001, 0, 3, 8'h7E, 1);
        add("t5_r0",     0, 4'b1001, 1, 4'b0000, 1, 0, 8'hF0, 1);
        add("t5_i0",     0, 4'b0000, 1, 4'b0000, 0, 0, 8'hF0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            chk(tbl[i].name, tbl[i].gnt, tbl[i].vld, tbl[i].id, tbl[i].y, tbl[i].busy);
        end

        // Stalled response (ptr=1): result and id stay put, late req and operand changes ignored
        step(0, 4'b0010, 0);
        chk("t4_gnt", 4'b0010, 0, 0, 8'hF0, 1);
        @(negedge clk);
        bus.a_in = '0;
        bus.b_in = '0;
        step(0, 4'b1000, 0);
        chk("t4_rsp", 4'b0000, 1, 1, 8'hCF, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1000, 0);
            chk("t4_hold", 4'b0000, 1, 1, 8'hCF, 1);
        end
        @(negedge clk);
        bus.a_in = A_OPS;
        bus.b_in = B_OPS;
        step(0, 4'b0000, 1);
        chk("t4_accept", 4'b0000, 0, 1, 8'hCF, 0);
        step(0, 4'b0000, 1);
        chk("t4_idle", 4'b0000, 0, 1, 8'hCF, 0);

        // Reset during EVAL (ptr=2 so requester 0 wins after wrap): no response follows
        step(0, 4'b0001, 1);
        chk("rst_eval_gnt", 4'b0001, 0, 1, 8'hCF, 1);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        #1;
        chk("rst_eval_async", 4'b0000, 0, 0, 8'h00, 0);
        step(0, 4'b0000, 1);
        chk("rst_eval_norsp", 4'b0000, 0, 0, 8'h00, 0);

        // Reset during RESP: ptr must return to 0 so requester 1 wins over 2
        step(0, 4'b0010, 0);
        chk("t6_gnt", 4'b0010, 0, 0, 8'h00, 1);
        step(0, 4'b0000, 0);
        chk("t6_rsp", 4'b0000, 1, 1, 8'hCF, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_async", 4'b0000, 0, 0, 8'h00, 0);
        step(0, 4'b0110, 1);
        chk("t6_regnt", 4'b0010, 0, 0, 8'h00, 1);
        step(0, 4'b0000, 1);
        chk("t6_rersp", 4'b0000, 1, 1, 8'hCF, 1);
        step(0, 4'b0000, 1);
        chk("t6_idle", 4'b0000, 0, 1, 8'hCF, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
